alu: RTL and testbench

32-bit integer ALU for the datapath execute stage, selecting one of 14 logic, shift, set-compare and add/subtract operations from six one-bit select lines. Operands and selects are sampled combinationally; the result is registered, giving one cycle of latency. It sits between the operand-forwarding muxes and the execute/memory pipeline register.

---
 rtl/alu.sv | 78 +++++++
 tb/tb_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit execute-stage ALU: logic, shift, signed set-compare, add/sub.
// Ports: clk, rst_n (sync, active-low), in1, in2, sel0..sel5 -> out (registered).
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        sel0,
  input  logic        sel1,
  input  logic        sel2,
  input  logic        sel3,
  input  logic        sel4,
  input  logic        sel5,
  output logic [31:0] out
);

  logic [5:0]  op;
  logic [4:0]  shamt;
  logic        lt;
  logic        eq;
  logic [31:0] out_d;
  logic [31:0] out_q;

  logic is_and, is_or, is_xor;
  logic is_sll, is_sra, is_srl;
  logic is_add, is_sub;
  logic is_seq, is_sne, is_slt;
  logic is_sgt, is_sle, is_sge;

  assign op    = {sel5, sel4, sel3, sel2, sel1, sel0};
  assign shamt = in2[4:0];
  assign lt    = $signed(in1) < $signed(in2);
  assign eq    = in1 == in2;

  assign is_and = op == 6'b000000;
  assign is_or  = op == 6'b000001;
  assign is_xor = op == 6'b000010;
  assign is_sll = op == 6'b000110;
  assign is_sra = op == 6'b000100;
  assign is_srl = op == 6'b000101;
  assign is_add = op == 6'b100000;
  assign is_sub = op == 6'b111000;
  assign is_seq = op == 6'b110000;
  assign is_sne = op == 6'b110001;
  assign is_slt = op == 6'b110010;
  assign is_sgt = op == 6'b110011;
  assign is_sle = op == 6'b110100;
  assign is_sge = op == 6'b110110;

  always_comb begin
    out_d = '0;
    unique case (1'b1)
      is_and: out_d = in1 & in2;
      is_or:  out_d = in1 | in2;
      is_xor: out_d = in1 ^ in2;
      is_sll: out_d = in1 << shamt;
      is_sra: out_d = 32'($signed(in1) >>> shamt);
      is_srl: out_d = in1 >> shamt;
      is_add: out_d = in1 + in2;
      is_sub: out_d = in1 - in2;
      is_seq: out_d = {31'b0, eq};
      is_sne: out_d = {31'b0, ~eq};
      is_slt: out_d = {31'b0, lt};
      is_sgt: out_d = {31'b0, ~lt & ~eq};
      is_sle: out_d = {31'b0, lt | eq};
      is_sge: out_d = {31'b0, ~lt};
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu.
// Scoreboard queue of expected results, checked one edge after drive.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2, out;
  logic        sel0, sel1, sel2, sel3, sel4, sel5;

  always #5 clk = ~clk;

  alu dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .in2  (in2),
    .sel0 (sel0),
    .sel1 (sel1),
    .sel2 (sel2),
    .sel3 (sel3),
    .sel4 (sel4),
    .sel5 (sel5),
    .out  (out)
  );

  localparam logic [5:0] OP_AND = 6'b000000;
  localparam logic [5:0] OP_OR  = 6'b000001;
  localparam logic [5:0] OP_XOR = 6'b000010;
  localparam logic [5:0] OP_SLL = 6'b000110;
  localparam logic [5:0] OP_SRA = 6'b000100;
  localparam logic [5:0] OP_SRL = 6'b000101;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b111000;
  localparam logic [5:0] OP_SEQ = 6'b110000;
  localparam logic [5:0] OP_SNE = 6'b110001;
  localparam logic [5:0] OP_SLT = 6'b110010;
  localparam logic [5:0] OP_SGT = 6'b110011;
  localparam logic [5:0] OP_SLE = 6'b110100;
  localparam logic [5:0] OP_SGE = 6'b110110;

  logic [31:0] exp_q[$];
  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [5:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = a;
    case (op)
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SLL: begin
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0};
        return r;
      end
      OP_SRA: begin
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]};
        return r;
      end
      OP_SRL: begin
        for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]};
        return r;
      end
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_SEQ: return (sa == sb) ? 32'd1 : 32'd0;
      OP_SNE: return (sa != sb) ? 32'd1 : 32'd0;
      OP_SLT: return (sa <  sb) ? 32'd1 : 32'd0;
      OP_SGT: return (sa >  sb) ? 32'd1 : 32'd0;
      OP_SLE: return (sa <= sb) ? 32'd1 : 32'd0;
      OP_SGE: return (sa >= sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input string tag,
                      input logic [5:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic rst = 1'b1);
    @(negedge clk);
    {sel5, sel4, sel3, sel2, sel1, sel0} = op;
    in1   = a;
    in2   = b;
    rst_n = rst;
    exp_q.push_back(rst ? model(op, a, b) : 32'd0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      chk(tag, out, exp_q.pop_front());
    end
  endtask

  task automatic step_known(input string tag,
                            input logic [5:0] op,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [31:0] want);
    chk({tag, "_model"}, model(op, a, b), want);
    step(tag, op, a, b);
  endtask

  logic [5:0] ops [14];
  logic [31:0] ra, rb;

  initial begin
    ops = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRA, OP_SRL, OP_ADD,
            OP_SUB, OP_SEQ, OP_SNE, OP_SLT, OP_SGT, OP_SLE, OP_SGE};
    rst_n = 1'b0;
    in1 = '0;
    in2 = '0;
    {sel5, sel4, sel3, sel2, sel1, sel0} = OP_ADD;

    step("rst0", OP_ADD, 32'h1234_5678, 32'h1, 1'b0);
    step("rst1", OP_OR, 32'hFFFF_FFFF, 32'h1, 1'b0);

    step_known("and", OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
    step_known("or",  OP_OR,  32'hF0F0_1234, 32'hFF00_FF00, 32'hFFF0_FF34);
    step_known("xor", OP_XOR, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0FF0_ED34);

    step_known("sll4", OP_SLL, 32'h8000_00F0, 32'd4, 32'h0000_0F00);
    step_known("sra4", OP_SRA, 32'h8000_00F0, 32'd4, 32'hF800_000F);
    step_known("srl4", OP_SRL, 32'h8000_00F0, 32'd4, 32'h0800_000F);
    step_known("sll0", OP_SLL, 32'h8000_00F0, 32'd0, 32'h8000_00F0);
    step_known("sra0", OP_SRA, 32'h8000_00F0, 32'd0, 32'h8000_00F0);
    step_known("srlhi", OP_SRL, 32'h8000_00F0, 32'hFFFF_FFE3, 32'h1000_001E);
    step_known("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);

    step_known("slt01", OP_SLT, 32'd0, 32'd1, 32'd1);
    step_known("sgt10", OP_SGT, 32'd1, 32'd0, 32'd1);
    step_known("seq55", OP_SEQ, 32'd5, 32'd5, 32'd1);
    step_known("sne55", OP_SNE, 32'd5, 32'd5, 32'd0);
    step_known("sle77", OP_SLE, 32'd7, 32'd7, 32'd1);
    step_known("sge67", OP_SGE, 32'd6, 32'd7, 32'd0);
    step_known("sltneg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    step_known("sgtneg", OP_SGT, 32'hFFFF_FFFF, 32'd1, 32'd0);

    step_known("addwrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    step_known("addovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    step_known("sub35", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);

    step_known("op03", 6'b000011, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    step_known("op3f", 6'b111111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);

    step("add_pre", OP_ADD, 32'h1111_1111, 32'h2222_2222);
    step("add_rst", OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0);
    step("add_post", OP_ADD, 32'h1111_1111, 32'h2222_2222);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 14; i++) begin
        ra = $urandom;
        rb = (r == 0) ? ra : $urandom;
        step($sformatf("b2b_r%0d_op%02h", r, ops[i]), ops[i], ra, rb);
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      step($sformatf("rnd%0d", i), 6'($urandom_range(0, 63)), ra, rb);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
